// File: rtl/int16_op_sequencer.sv
// Issue stage for the 16-bit integer units: accepts one op, enables the selected
// unit, waits for done (with timeout), and holds the result on a valid/ready output.
module int16_op_sequencer #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] u_a,
  output logic [15:0] u_b,
  output logic        add_en,
  output logic        sub_en,
  output logic        mul_en,
  output logic        div_en,
  input  logic        add_done,
  input  logic        sub_done,
  input  logic        mul_done,
  input  logic        div_done,
  input  logic [15:0] add_out,
  input  logic [15:0] sub_out,
  input  logic [15:0] mul_out,
  input  logic [15:0] div_out,
  input  logic [15:0] div_rem,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_res,
  output logic [15:0] out_rem,
  output logic        out_err,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0]  OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_DIV_WAIT, S_DIV_SETTLE, S_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] u_a_q, u_a_d, u_b_q, u_b_d;
  logic [15:0] res_q, res_d, rem_q, rem_d;
  logic        err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  en_q, en_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        sel_done;
  logic [15:0] sel_out;
  logic        timed_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      u_a_q   <= '0;
      u_b_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      en_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      u_a_q   <= u_a_d;
      u_b_q   <= u_b_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Completion and result of the unit selected by the latched op
  always_comb begin
    sel_done = 1'b0;
    sel_out  = '0;
    case (op_q)
      2'd0: begin sel_done = add_done; sel_out = add_out; end
      2'd1: begin sel_done = sub_done; sel_out = sub_out; end
      2'd2: begin sel_done = mul_done; sel_out = mul_out; end
      2'd3: begin sel_done = div_done; sel_out = div_out; end
    endcase
  end

  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    u_a_d   = u_a_q;
    u_b_d   = u_b_q;
    res_d   = res_q;
    rem_d   = rem_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    en_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = in_op;
          u_a_d = in_a;
          u_b_d = in_b;
          cnt_d = '0;
          if (in_op == OP_DIV && in_b == 16'h0000) begin
            res_d   = in_a[15] ? 16'h8000 : 16'h7FFF;
            rem_d   = in_a;
            err_d   = 1'b1;
            state_d = S_OUT;
          end else if (in_op == OP_DIV) begin
            state_d = S_DIV_WAIT;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (sel_done) begin
          res_d   = sel_out;
          rem_d   = '0;
          err_d   = 1'b0;
          state_d = S_OUT;
        end else if (timed_out) begin
          res_d   = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // The divider's result is corrected on the done edge; capture one cycle later
      S_DIV_WAIT: begin
        if (div_done) begin
          state_d = S_DIV_SETTLE;
        end else if (timed_out) begin
          res_d   = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV_SETTLE: begin
        res_d   = div_out;
        rem_d   = div_rem;
        err_d   = 1'b0;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_EXEC) en_d = 4'b0001 << op_d;
    if (state_d == S_DIV_WAIT || state_d == S_DIV_SETTLE) en_d = 4'b1000;
    valid_d = (state_d == S_OUT);
    busy_d  = (state_d != S_IDLE);
  end

  assign in_ready  = (state_q == S_IDLE);
  assign u_a       = u_a_q;
  assign u_b       = u_b_q;
  assign add_en    = en_q[0];
  assign sub_en    = en_q[1];
  assign mul_en    = en_q[2];
  assign div_en    = en_q[3];
  assign out_valid = valid_q;
  assign out_res   = res_q;
  assign out_rem   = rem_q;
  assign out_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_int16_op_sequencer.sv
// Bench for int16_op_sequencer: behavioural unit models, a directed vector table,
// randomized ops against a reference model, and a reset-during-divide sequence.
module tb_int16_op_sequencer;

  localparam int TIMEOUT = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_a, in_b, u_a, u_b;
  logic        add_en, sub_en, mul_en, div_en;
  logic        add_done, sub_done, mul_done, div_done;
  logic [15:0] add_out, sub_out, mul_out, div_out, div_rem;
  logic        out_valid, out_ready;
  logic [15:0] out_res, out_rem;
  logic        out_err, busy;
  logic        mul_stuck;
  logic [4:0]  dcnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  int16_op_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .u_a(u_a), .u_b(u_b),
    .add_en(add_en), .sub_en(sub_en), .mul_en(mul_en), .div_en(div_en),
    .add_done(add_done), .sub_done(sub_done), .mul_done(mul_done), .div_done(div_done),
    .add_out(add_out), .sub_out(sub_out), .mul_out(mul_out), .div_out(div_out),
    .div_rem(div_rem),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_rem(out_rem),
    .out_err(out_err), .busy(busy)
  );

  function automatic logic [15:0] f_mul(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = $signed(a) * $signed(b);
    if (p > 32767) return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return 16'(p);
  endfunction

  function automatic logic [15:0] f_mag(input logic [15:0] x);
    return x[15] ? 16'(-x) : x;
  endfunction

  function automatic logic [15:0] f_quo(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] q;
    if (b == 16'h0) return 16'h0;
    q = f_mag(a) / f_mag(b);
    return (a[15] ^ b[15]) ? 16'(-q) : q;
  endfunction

  function automatic logic [15:0] f_rem(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'h0) return 16'h0;
    return f_mag(a) % f_mag(b);
  endfunction

  // Unit models: add/sub/mul answer in the enable cycle; divider takes 17 cycles
  // and publishes its corrected result on the done edge (garbage before that).
  assign add_done = add_en;
  assign sub_done = sub_en;
  assign mul_done = mul_en & ~mul_stuck;
  assign add_out  = u_a + u_b;
  assign sub_out  = u_a - u_b;
  assign mul_out  = f_mul(u_a, u_b);
  assign div_done = div_en && (dcnt == 5'd16);

  always_ff @(posedge clk) begin
    if (!div_en) dcnt <= 5'd0;
    else         dcnt <= dcnt + 5'd1;
    if (div_done) begin
      div_out <= f_quo(u_a, u_b);
      div_rem <= f_rem(u_a, u_b);
    end else if (!div_en) begin
      div_out <= 16'hDEAD;
      div_rem <= 16'hBEEF;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference from the operation rules: result, remainder, error, latency, enable cycles
  task automatic ref_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic [15:0] rem,
                           output logic err, output int lat, output int ens);
    rem = 16'h0; err = 1'b0; lat = 2; ens = 1;
    case (op)
      2'd0: res = a + b;
      2'd1: res = a - b;
      2'd2: res = f_mul(a, b);
      default: begin
        if (b == 16'h0) begin
          res = a[15] ? 16'h8000 : 16'h7FFF; rem = a; err = 1'b1; lat = 1; ens = 0;
        end else begin
          res = f_quo(a, b); rem = f_rem(a, b); lat = 19; ens = 18;
        end
      end
    endcase
  endtask

  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic stuck, input int hold,
                       input logic [15:0] e_res, input logic [15:0] e_rem, input logic e_err,
                       input int e_lat, input int e_ens);
    int g, k, enc, wrong;
    logic [3:0] allowed;
    mul_stuck = stuck;
    allowed = 4'b0001 << op;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = (hold == 0);
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    chk("accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_op = 2'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
    k = 1; enc = 0; wrong = 0;
    while (!out_valid && k < 200) begin
      if (add_en | sub_en | mul_en | div_en) enc++;
      if (({div_en, mul_en, sub_en, add_en} & ~allowed) != 4'b0) wrong++;
      @(negedge clk); k++;
    end
    chk("latency", 32'(k), 32'(e_lat));
    chk("en_cycles", 32'(enc), 32'(e_ens));
    chk("wrong_en", 32'(wrong), 32'd0);
    chk("out_res", 32'(out_res), 32'(e_res));
    chk("out_rem", 32'(out_rem), 32'(e_rem));
    chk("out_err", 32'(out_err), 32'(e_err));
    chk("u_a", 32'(u_a), 32'(a));
    chk("u_b", 32'(u_b), 32'(b));
    for (int i = 0; i < hold; i++) begin
      chk("hold_res", 32'(out_res), 32'(e_res));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    mul_stuck = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        stuck;
    int          hold;
    logic [15:0] res, rem;
    logic        err;
    int          lat, ens;
  } vec_t;

  initial begin
    vec_t tbl[10];
    logic [1:0]  r_op;
    logic [15:0] r_a, r_b, e_res, e_rem;
    logic        e_err;
    int          e_lat, e_ens;

    tbl[0] = '{2'd0, 16'h0005, 16'hFFFD, 1'b0, 0,  16'h0002, 16'h0000, 1'b0, 2, 1};
    tbl[1] = '{2'd2, 16'h4000, 16'h0004, 1'b0, 0,  16'h7FFF, 16'h0000, 1'b0, 2, 1};
    tbl[2] = '{2'd2, 16'h4000, 16'hFFFC, 1'b0, 0,  16'h8000, 16'h0000, 1'b0, 2, 1};
    tbl[3] = '{2'd3, 16'hFFF9, 16'h0002, 1'b0, 0,  16'hFFFD, 16'h0001, 1'b0, 19, 18};
    tbl[4] = '{2'd3, 16'h0064, 16'h0007, 1'b0, 0,  16'h000E, 16'h0002, 1'b0, 19, 18};
    tbl[5] = '{2'd3, 16'h8123, 16'h0000, 1'b0, 0,  16'h8000, 16'h8123, 1'b1, 1, 0};
    tbl[6] = '{2'd1, 16'h1234, 16'h0234, 1'b0, 10, 16'h1000, 16'h0000, 1'b0, 2, 1};
    tbl[7] = '{2'd2, 16'h1234, 16'h5678, 1'b1, 0,  16'h0000, 16'h0000, 1'b1, 64, 63};
    tbl[8] = '{2'd3, 16'h7000, 16'h0000, 1'b0, 2,  16'h7FFF, 16'h7000, 1'b1, 1, 0};
    tbl[9] = '{2'd1, 16'h8000, 16'h0001, 1'b0, 0,  16'h7FFF, 16'h0000, 1'b0, 2, 1};

    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = 16'h0; in_b = 16'h0;
    out_ready = 1'b0; mul_stuck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);
    chk("rst_out_rem", 32'(out_rem), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_u_ab", {u_a, u_b}, 32'd0);
    chk("rst_en", 32'({add_en, sub_en, mul_en, div_en}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].stuck, tbl[i].hold,
            tbl[i].res, tbl[i].rem, tbl[i].err, tbl[i].lat, tbl[i].ens);

    // Reset while the divider is running, then a normal add
    @(negedge clk);
    chk("rdiv_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = 2'd3; in_a = 16'hFFF9; in_b = 16'h0002;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rdiv_div_en", 32'(div_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rdiv_div_en_low", 32'(div_en), 32'd0);
    chk("rdiv_busy", 32'(busy), 32'd0);
    chk("rdiv_out_valid", 32'(out_valid), 32'd0);
    chk("rdiv_in_ready2", 32'(in_ready), 32'd1);
    do_op(2'd0, 16'h0100, 16'h0023, 1'b0, 0, 16'h0123, 16'h0000, 1'b0, 2, 1);

    for (int n = 0; n < 40; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = 16'($urandom);
      r_b  = (r_op == 2'd3 && $urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      ref_model(r_op, r_a, r_b, e_res, e_rem, e_err, e_lat, e_ens);
      do_op(r_op, r_a, r_b, 1'b0, int'($urandom_range(0, 3)), e_res, e_rem, e_err, e_lat, e_ens);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
